// File: rtl/clock_pkg.sv
// Shared constants and FSM encoding for the digital-clock I/O blocks
// (beep pattern generator and button debouncer).
package clock_pkg;

  localparam int unsigned CLK_FREQ_HZ     = 100_000_000;
  localparam int unsigned BEEP_ON_CYCLES  = 10_000_000;  // 100 ms
  localparam int unsigned BEEP_OFF_CYCLES = 10_000_000;  // 100 ms
  localparam int unsigned BEEP_CNT_W      = 24;
  localparam int unsigned DEBOUNCE_CYCLES = 1_000_000;   // 10 ms

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } beep_state_t;

endpackage

// File: rtl/tc_counter.sv
// Loadable down-counter that parks at zero; o_tc flags the zero (terminal) count.
module tc_counter #(
  parameter int unsigned W = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset)               r_cnt <= '0;
    else if (i_load)         r_cnt <= i_load_val;
    else if (r_cnt != '0)    r_cnt <= r_cnt - W'(1);
  end

  assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/beep_pattern_gen.sv
// Turns a one-cycle trigger into N timed beeps on a buzzer/LED line,
// with cancel, a completion pulse and a busy flag (all registered).
module beep_pattern_gen
  import clock_pkg::*;
#(
  parameter int unsigned ON_CYCLES  = BEEP_ON_CYCLES,
  parameter int unsigned OFF_CYCLES = BEEP_OFF_CYCLES,
  parameter int unsigned CNT_W      = BEEP_CNT_W,
  parameter int unsigned BEEPS_W    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               trig_i,
  input  logic [BEEPS_W-1:0] count_i,
  input  logic               cancel_i,
  output logic               beep_o,
  output logic               busy_o,
  output logic               done_o
);

  // Counter runs load_val..0, so a phase lasts load_val+1 cycles.
  localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYCLES - 1);

  beep_state_t        r_state, w_state_nxt;
  logic [BEEPS_W-1:0] r_remain, w_remain_nxt;
  logic               w_load, w_tc;
  logic [CNT_W-1:0]   w_load_val;
  logic               w_done_nxt;
  logic               r_beep, r_busy, r_done;

  tc_counter #(.W(CNT_W)) u_dur (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_tc       (w_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_remain <= '0;
      r_beep   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_remain <= w_remain_nxt;
      r_beep   <= (w_state_nxt == ON);
      r_busy   <= (w_state_nxt != IDLE);
      r_done   <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_remain_nxt = r_remain;
    w_load       = 1'b0;
    w_load_val   = '0;
    w_done_nxt   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (trig_i && !cancel_i && (count_i != '0)) begin
          w_state_nxt  = ON;
          w_remain_nxt = count_i;
          w_load       = 1'b1;
          w_load_val   = ON_LOAD;
        end
      end
      ON: begin
        if (cancel_i) begin
          w_state_nxt = IDLE;
          w_load      = 1'b1;
        end else if (w_tc) begin
          w_remain_nxt = r_remain - BEEPS_W'(1);
          if (r_remain == BEEPS_W'(1)) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = OFF;
            w_load      = 1'b1;
            w_load_val  = OFF_LOAD;
          end
        end
      end
      OFF: begin
        if (cancel_i) begin
          w_state_nxt = IDLE;
          w_load      = 1'b1;
        end else if (w_tc) begin
          w_state_nxt = ON;
          w_load      = 1'b1;
          w_load_val  = ON_LOAD;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign beep_o = r_beep;
  assign busy_o = r_busy;
  assign done_o = r_done;

endmodule

// File: tb/tb_beep_pattern_gen.sv
// Directed + randomized bench for beep_pattern_gen against a position-based
// timing model (ON=3, OFF=2).
module tb_beep_pattern_gen;

  localparam int ON  = 3;
  localparam int OFF = 2;
  localparam int P   = ON + OFF;

  logic       clk = 1'b0;
  logic       reset, trig_i, cancel_i;
  logic [3:0] count_i;
  logic       beep_o, busy_o, done_o;

  always #5 clk = ~clk;

  beep_pattern_gen #(
    .ON_CYCLES  (ON),
    .OFF_CYCLES (OFF),
    .CNT_W      (4),
    .BEEPS_W    (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .trig_i   (trig_i),
    .count_i  (count_i),
    .cancel_i (cancel_i),
    .beep_o   (beep_o),
    .busy_o   (busy_o),
    .done_o   (done_o)
  );

  int checks   = 0;
  int failures = 0;
  int cyc_n    = 0;

  // Model: m_p is the 1-based output cycle within the active pattern.
  bit m_busy = 0, m_done = 0, exp_beep = 0;
  int m_p = 0, m_n = 0;
  int rises = 0;
  bit prev_beep = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d cycle=%0d", tag, got, exp, cyc_n);
    end
  endtask

  task automatic model(input bit r, input bit t, input int c, input bit x);
    m_done = 0;
    if (r) m_busy = 0;
    else if (m_busy) begin
      if (x) m_busy = 0;
      else if (m_p == m_n * ON + (m_n - 1) * OFF) begin
        m_busy = 0;
        m_done = 1;
      end else m_p++;
    end else if (t && c != 0 && !x) begin
      m_busy = 1;
      m_p    = 1;
      m_n    = c;
    end
    exp_beep = m_busy && (((m_p - 1) % P) < ON);
  endtask

  task automatic step(input bit r, input bit t, input int c, input bit x);
    reset    = r;
    trig_i   = t;
    count_i  = 4'(c);
    cancel_i = x;
    @(posedge clk);
    model(r, t, c, x);
    @(negedge clk);
    cyc_n++;
    chk("beep", {31'b0, beep_o}, {31'b0, exp_beep});
    chk("busy", {31'b0, busy_o}, {31'b0, m_busy});
    chk("done", {31'b0, done_o}, {31'b0, m_done});
    if (beep_o && !prev_beep) rises++;
    prev_beep = beep_o;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0);
  endtask

  initial begin
    // reset with a trigger pending
    step(1, 1, 3, 0);
    step(1, 1, 3, 0);
    idle(2);
    // two-beep pattern
    step(0, 1, 2, 0); idle(11);
    // zero count ignored
    step(0, 1, 0, 0); idle(3);
    // trigger while busy ignored
    step(0, 1, 3, 0); idle(1); step(0, 1, 5, 0); idle(14);
    // cancel during OFF phase
    step(0, 1, 4, 0); idle(4); step(0, 0, 0, 1); idle(5);
    // back-to-back: retrigger in done cycle
    step(0, 1, 1, 0); idle(3); step(0, 1, 1, 0);
    chk("b2b_beep", {31'b0, beep_o}, 32'd1);
    idle(5);
    // max count
    rises = 0;
    step(0, 1, 15, 0); idle(80);
    chk("max_phases", rises, 32'd15);
    // trigger and cancel together in IDLE
    step(0, 1, 3, 1);
    chk("trig_cancel_busy", {31'b0, busy_o}, 32'd0);
    idle(3);
    // randomized traffic
    repeat (3000) begin
      bit r, t, x;
      int c;
      r = ($urandom_range(0, 299) == 0);
      t = ($urandom_range(0, 5) == 0);
      x = ($urandom_range(0, 39) == 0);
      c = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 4));
      step(r, t, c, x);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
